// File: rtl/reg_sgpr_mw_pkg.sv
// Shared types and constants for the two-write-path scalar GPR file:
// LSU burst record, sequencer states and the special register map.
package reg_sgpr_mw_pkg;

  localparam int SGPR_BANKS          = 16;
  localparam int SGPR_DEPTH          = 128;
  localparam int SGPR_DW             = 32;
  localparam int SGPR_LSU_FIFO_DEPTH = 4;
  localparam int SGPR_LSU_MAX_DW     = 16;
  localparam int SGPR_BANK_W         = $clog2(SGPR_BANKS);
  localparam int SGPR_ADDR_W         = $clog2(SGPR_DEPTH);
  localparam int SGPR_CNT_W          = $clog2($clog2(SGPR_LSU_MAX_DW) + 1);

  localparam logic [SGPR_ADDR_W-1:0] VCC_LO    = 7'd106;
  localparam logic [SGPR_ADDR_W-1:0] VCC_HI    = 7'd107;
  localparam logic [SGPR_ADDR_W-1:0] NULL_ADDR = 7'd125;
  localparam logic [SGPR_ADDR_W-1:0] EXEC_LO   = 7'd126;
  localparam logic [SGPR_ADDR_W-1:0] EXEC_HI   = 7'd127;

  typedef struct packed {
    logic [SGPR_BANK_W-1:0]                     bank;
    logic [SGPR_ADDR_W-1:0]                     addr;
    logic [SGPR_CNT_W-1:0]                      cnt;
    logic [SGPR_LSU_MAX_DW-1:0][SGPR_DW-1:0]    data;
  } sgpr_lsu_burst_t;

  typedef enum logic {
    SEQ_IDLE,
    SEQ_WRITE
  } sgpr_seq_e;

  // cnt 0: any address; cnt 1: even; larger bursts: 4-dword aligned
  function automatic logic lsu_aligned(input logic [SGPR_ADDR_W-1:0] addr,
                                       input logic [SGPR_CNT_W-1:0]  cnt);
    if (cnt == '0) return 1'b1;
    if (cnt == SGPR_CNT_W'(1)) return !addr[0];
    return addr[1:0] == 2'b00;
  endfunction

  // Index of the final two-dword beat of a burst of 2^cnt dwords
  function automatic int lsu_last_beat(input logic [SGPR_CNT_W-1:0] cnt);
    return (cnt == '0) ? 0 : (1 << (int'(cnt) - 1)) - 1;
  endfunction

endpackage

// File: rtl/reg_sgpr_mw_lsu_fifo.sv
// Synchronous FIFO of LSU bursts; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module sgpr_lsu_fifo
  import reg_sgpr_mw_pkg::*;
#(
  parameter int DEPTH = SGPR_LSU_FIFO_DEPTH,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_i,
  input  sgpr_lsu_burst_t din_i,
  input  logic            pop_i,
  output sgpr_lsu_burst_t dout_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [PW:0]     count_o
);

  sgpr_lsu_burst_t mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     count_q;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (int'(count_q) == DEPTH);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/reg_sgpr_mw.sv
// Banked scalar GPR file: ALU write port with bypass, plus a buffered LSU
// burst port drained two dwords per cycle whenever the ALU port is idle.
module reg_sgpr_mw
  import reg_sgpr_mw_pkg::*;
#(
  parameter int RD_PORTS       = 2,
  parameter int DATA_WIDTH     = SGPR_DW,
  parameter int DEPTH          = SGPR_DEPTH,
  parameter int BANKS          = SGPR_BANKS,
  parameter int LSU_FIFO_DEPTH = SGPR_LSU_FIFO_DEPTH,
  parameter int LSU_MAX_DW     = SGPR_LSU_MAX_DW,
  parameter int WAVE32_ONLY    = 1,
  localparam int AW            = $clog2(DEPTH),
  localparam int BW            = $clog2(BANKS),
  localparam int CW            = $clog2($clog2(LSU_MAX_DW) + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [BW-1:0]                        rd_bank_sel,
  input  logic [RD_PORTS-1:0][AW-1:0]          raddr,
  output logic [RD_PORTS-1:0][DATA_WIDTH-1:0]  rdata_lo,
  output logic [RD_PORTS-1:0][DATA_WIDTH-1:0]  rdata_hi,
  input  logic [BW-1:0]                        wr_bank_sel,
  input  logic [AW-1:0]                        waddr,
  input  logic [2*DATA_WIDTH-1:0]              wdata,
  input  logic [1:0]                           wstrb,
  input  logic                                 wenable,
  input  logic                                 lsu_valid,
  output logic                                 lsu_ready,
  input  logic [BW-1:0]                        lsu_bank,
  input  logic [AW-1:0]                        lsu_addr,
  input  logic [CW-1:0]                        lsu_cnt,
  input  logic [LSU_MAX_DW-1:0][DATA_WIDTH-1:0] lsu_data,
  output logic [BANKS-1:0]                     lsu_pending,
  input  logic                                 wave64_mode,
  output logic [BANKS-1:0][DATA_WIDTH-1:0]     exec,
  output logic [BANKS-1:0][DATA_WIDTH-1:0]     vcc,
  output logic [BANKS-1:0]                     execz,
  output logic [BANKS-1:0]                     vccz,
  input  logic                                 vcc_en,
  input  logic [BW-1:0]                        vcc_bank_sel,
  input  logic [DATA_WIDTH-1:0]                vcc_data
);

  localparam int BT_W = $clog2(LSU_MAX_DW) - 1;
  localparam int QW   = $clog2(LSU_FIFO_DEPTH + 1);
  localparam int NWS  = 4;

  logic [DATA_WIDTH-1:0] rf_q [BANKS][DEPTH];

  sgpr_lsu_burst_t fifo_din, fifo_dout, burst_q, burst_d;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(LSU_FIFO_DEPTH):0] fifo_count;
  sgpr_seq_e       state_q, state_d;
  logic [BT_W-1:0] beat_q, beat_d;
  logic            lsu_we, last_beat, rdy_q;
  logic [QW-1:0]   qcnt_q [BANKS];

  logic                  ws_en   [NWS];
  logic [BW-1:0]         ws_bank [NWS];
  logic [AW-1:0]         ws_addr [NWS];
  logic [DATA_WIDTH-1:0] ws_data [NWS];

  assign lsu_ready = rdy_q && !fifo_full && !reset;
  assign fifo_push = lsu_valid && lsu_ready;
  assign fifo_din  = '{bank: lsu_bank, addr: lsu_addr, cnt: lsu_cnt, data: lsu_data};
  assign last_beat = (int'(beat_q) == lsu_last_beat(burst_q.cnt));

  sgpr_lsu_fifo #(.DEPTH(LSU_FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    beat_d   = beat_q;
    fifo_pop = 1'b0;
    lsu_we   = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          burst_d  = fifo_dout;
          beat_d   = '0;
          state_d  = SEQ_WRITE;
        end
      end
      SEQ_WRITE: begin
        // ALU traffic owns the write port; the beat simply waits
        if (!wenable) begin
          lsu_we = 1'b1;
          if (last_beat) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              burst_d  = fifo_dout;
              beat_d   = '0;
            end else begin
              state_d = SEQ_IDLE;
            end
          end else begin
            beat_d = beat_q + BT_W'(1);
          end
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEQ_IDLE;
      beat_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rdy_q   <= 1'b1;
    end
    burst_q <= burst_d;
  end

  // Per-bank count of queued bursts, so pending needs no FIFO peeking
  always_ff @(posedge clk) begin
    for (int b = 0; b < BANKS; b++) begin
      if (reset) begin
        qcnt_q[b] <= '0;
      end else begin
        case ({fifo_push && (lsu_bank == BW'(b)), fifo_pop && (fifo_dout.bank == BW'(b))})
          2'b10:   qcnt_q[b] <= qcnt_q[b] + QW'(1);
          2'b01:   qcnt_q[b] <= qcnt_q[b] - QW'(1);
          default: qcnt_q[b] <= qcnt_q[b];
        endcase
      end
    end
  end

  always_comb begin
    for (int b = 0; b < BANKS; b++)
      lsu_pending[b] = (qcnt_q[b] != '0) || (state_q == SEQ_WRITE && burst_q.bank == BW'(b));
  end

  always_comb begin
    ws_en[0]   = wenable && wstrb[0];
    ws_bank[0] = wr_bank_sel;
    ws_addr[0] = waddr;
    ws_data[0] = wdata[DATA_WIDTH-1:0];
    ws_en[1]   = wenable && wstrb[1] && !waddr[0];
    ws_bank[1] = wr_bank_sel;
    ws_addr[1] = waddr + AW'(1);
    ws_data[1] = wdata[2*DATA_WIDTH-1:DATA_WIDTH];
    ws_bank[2] = burst_q.bank;
    ws_bank[3] = burst_q.bank;
    if (burst_q.cnt == '0) begin
      ws_en[2]   = lsu_we;
      ws_addr[2] = burst_q.addr;
      ws_data[2] = burst_q.data[0];
      ws_en[3]   = 1'b0;
      ws_addr[3] = burst_q.addr;
      ws_data[3] = burst_q.data[1];
    end else begin
      ws_en[2]   = lsu_we;
      ws_addr[2] = burst_q.addr + AW'({beat_q, 1'b0});
      ws_data[2] = burst_q.data[{beat_q, 1'b0}];
      ws_en[3]   = lsu_we;
      ws_addr[3] = burst_q.addr + AW'({beat_q, 1'b1});
      ws_data[3] = burst_q.data[{beat_q, 1'b1}];
    end
    for (int s = 0; s < NWS; s++)
      if (ws_addr[s] == NULL_ADDR) ws_en[s] = 1'b0;
  end

  // Side VCC write first so a same-cycle ALU write to VCC_LO overrides it
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < BANKS; b++)
        for (int a = 0; a < DEPTH; a++)
          rf_q[b][a] <= (AW'(a) == EXEC_LO || AW'(a) == EXEC_HI) ? '1 : '0;
    end else begin
      if (vcc_en) rf_q[vcc_bank_sel][VCC_LO] <= vcc_data;
      for (int s = 0; s < NWS; s++)
        if (ws_en[s]) rf_q[ws_bank[s]][ws_addr[s]] <= ws_data[s];
    end
  end

  function automatic logic [DATA_WIDTH-1:0] rd_dword(input logic [BW-1:0] bank,
                                                     input logic [AW-1:0] addr);
    logic [DATA_WIDTH-1:0] v;
    v = rf_q[bank][addr];
    for (int s = 0; s < NWS; s++)
      if (ws_en[s] && ws_bank[s] == bank && ws_addr[s] == addr) v = ws_data[s];
    if (addr == NULL_ADDR) v = '0;
    return v;
  endfunction

  always_comb begin
    for (int p = 0; p < RD_PORTS; p++) begin
      rdata_lo[p] = rd_dword(rd_bank_sel, raddr[p]);
      rdata_hi[p] = raddr[p][0] ? '0 : rd_dword(rd_bank_sel, raddr[p] + AW'(1));
    end
  end

  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      exec[b] = rf_q[b][EXEC_LO];
      vcc[b]  = rf_q[b][VCC_LO];
      if (WAVE32_ONLY == 0 && wave64_mode) begin
        execz[b] = ~|{rf_q[b][EXEC_HI], rf_q[b][EXEC_LO]};
        vccz[b]  = ~|{rf_q[b][VCC_HI], rf_q[b][VCC_LO]};
      end else begin
        execz[b] = ~|rf_q[b][EXEC_LO];
        vccz[b]  = ~|rf_q[b][VCC_LO];
      end
    end
  end

  a_lsu_aligned: assert property (@(posedge clk) disable iff (reset)
    fifo_push |-> lsu_aligned(lsu_addr, lsu_cnt));
  a_fifo_bound: assert property (@(posedge clk) disable iff (reset)
    int'(fifo_count) <= LSU_FIFO_DEPTH);

endmodule

// File: tb/tb_reg_sgpr_mw.sv
// Directed bench for reg_sgpr_mw: reset state, LSU bursts, stalls, back-to-back
// drain, ALU bypass, NULL handling, VCC side write, flags and mid-burst reset.
module tb_reg_sgpr_mw;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        rd_bank_sel;
  logic [1:0][6:0]   raddr;
  logic [1:0][31:0]  rdata_lo, rdata_hi;
  logic [3:0]        wr_bank_sel;
  logic [6:0]        waddr;
  logic [63:0]       wdata;
  logic [1:0]        wstrb;
  logic              wenable;
  logic              lsu_valid, lsu_ready;
  logic [3:0]        lsu_bank;
  logic [6:0]        lsu_addr;
  logic [2:0]        lsu_cnt;
  logic [15:0][31:0] lsu_data;
  logic [15:0]       lsu_pending;
  logic              wave64_mode;
  logic [15:0][31:0] exec, vcc;
  logic [15:0]       execz, vccz;
  logic              vcc_en;
  logic [3:0]        vcc_bank_sel;
  logic [31:0]       vcc_data;

  int checks = 0;
  int errors = 0;
  int n;

  reg_sgpr_mw dut (
    .clk(clk), .reset(reset), .rd_bank_sel(rd_bank_sel), .raddr(raddr),
    .rdata_lo(rdata_lo), .rdata_hi(rdata_hi), .wr_bank_sel(wr_bank_sel),
    .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .wenable(wenable),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_bank(lsu_bank),
    .lsu_addr(lsu_addr), .lsu_cnt(lsu_cnt), .lsu_data(lsu_data),
    .lsu_pending(lsu_pending), .wave64_mode(wave64_mode), .exec(exec),
    .vcc(vcc), .execz(execz), .vccz(vccz), .vcc_en(vcc_en),
    .vcc_bank_sel(vcc_bank_sel), .vcc_data(vcc_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] b, input logic [6:0] a, input string tag,
                    input logic [31:0] ehi, input logic [31:0] elo);
    rd_bank_sel = b;
    raddr[0]    = a;
    #1;
    chk({tag, "_lo"}, rdata_lo[0], elo);
    chk({tag, "_hi"}, rdata_hi[0], ehi);
  endtask

  task automatic push(input logic [3:0] b, input logic [6:0] a, input logic [2:0] c,
                      input logic [31:0] base);
    lsu_valid = 1'b1;
    lsu_bank  = b;
    lsu_addr  = a;
    lsu_cnt   = c;
    for (int i = 0; i < 16; i++) lsu_data[i] = base + 32'(i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; rd_bank_sel = '0; raddr = '0; wr_bank_sel = '0; waddr = '0;
    wdata = '0; wstrb = '0; wenable = 1'b0; lsu_valid = 1'b0; lsu_bank = '0;
    lsu_addr = '0; lsu_cnt = '0; lsu_data = '0; wave64_mode = 1'b0;
    vcc_en = 1'b0; vcc_bank_sel = '0; vcc_data = '0;

    // Reset state
    step(); step();
    chk("rst_ready", lsu_ready, 0);
    chk("rst_pend", lsu_pending, 0);
    reset = 1'b0;
    step();
    chk("ready_after_rst", lsu_ready, 1);
    rd(4'd3, 7'd126, "rst_exec", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("rst_execz", execz, 0);
    rd(4'd2, 7'd8, "rst_r8", 32'h0, 32'h0);

    // Plain cnt-2 burst: two beats, pending tracks it
    push(4'd2, 7'd8, 3'd2, 32'h10);
    step();
    lsu_valid = 1'b0;
    chk("b2_pend_q", lsu_pending[2], 1);
    step();
    rd(4'd2, 7'd8, "b2_beat0_byp", 32'h11, 32'h10);
    chk("b2_pend_b0", lsu_pending[2], 1);
    step();
    chk("b2_pend_b1", lsu_pending[2], 1);
    step();
    chk("b2_pend_done", lsu_pending[2], 0);
    rd(4'd2, 7'd8, "b2_r8", 32'h11, 32'h10);
    rd(4'd2, 7'd10, "b2_r10", 32'h13, 32'h12);

    // Same shape burst stalled three cycles by ALU traffic after beat 0
    push(4'd4, 7'd8, 3'd2, 32'h20);
    step();
    lsu_valid = 1'b0;
    step();
    step();
    wenable = 1'b1; wr_bank_sel = 4'd4; waddr = 7'd20;
    wdata = 64'h0000_00BB_0000_00AA; wstrb = 2'b11;
    step(); step(); step();
    chk("stall_pend", lsu_pending[4], 1);
    rd(4'd4, 7'd10, "stall_r10", 32'h0, 32'h0);
    rd(4'd4, 7'd20, "stall_alu", 32'hBB, 32'hAA);
    wenable = 1'b0;
    step();
    chk("stall_pend_done", lsu_pending[4], 0);
    rd(4'd4, 7'd10, "stall_r10_late", 32'h23, 32'h22);
    rd(4'd4, 7'd8, "stall_r8", 32'h21, 32'h20);
    rd(4'd4, 7'd20, "stall_alu_kept", 32'hBB, 32'hAA);

    // Five cnt-4 bursts back to back; one sits in the sequencer, four fill the FIFO
    for (int k = 0; k < 5; k++) begin
      push(4'(5 + k), 7'd0, 3'd4, 32'h1000 * 32'(k + 1));
      #1;
      chk("fill_ready", lsu_ready, 1);
      step();
    end
    lsu_valid = 1'b0;
    chk("full_ready", lsu_ready, 0);
    n = 4;
    while (lsu_pending != 0 && n < 300) begin
      step();
      n++;
    end
    chk("drain_edges", 64'(n), 64'd41);
    rd(4'd9, 7'd14, "drain_b9", 32'h500F, 32'h500E);
    rd(4'd5, 7'd0, "drain_b5", 32'h1001, 32'h1000);
    chk("drain_ready", lsu_ready, 1);

    // ALU bypass on an odd address, then NULL handling
    wenable = 1'b1; wr_bank_sel = 4'd0; waddr = 7'd5;
    wdata = 64'h1234_5678_0000_CAFE; wstrb = 2'b01;
    rd(4'd0, 7'd5, "alu_byp", 32'h0, 32'hCAFE);
    step();
    wenable = 1'b0;
    rd(4'd0, 7'd5, "alu_reg", 32'h0, 32'hCAFE);
    rd(4'd0, 7'd4, "alu_r4_64", 32'hCAFE, 32'h0);
    wenable = 1'b1; waddr = 7'd125; wdata = 64'h0000_BEEF_0000_DEAD; wstrb = 2'b11;
    rd(4'd0, 7'd125, "null_byp", 32'h0, 32'h0);
    step();
    waddr = 7'd124; wdata = 64'h0000_BEEF_0000_1111;
    rd(4'd0, 7'd124, "m0_byp", 32'h0, 32'h1111);
    step();
    wenable = 1'b0;
    rd(4'd0, 7'd124, "m0_reg", 32'h0, 32'h1111);
    rd(4'd0, 7'd125, "null_reg", 32'h0, 32'h0);

    // VCC side write collides with an ALU VCC_LO write
    vcc_en = 1'b1; vcc_bank_sel = 4'd1; vcc_data = 32'h55;
    wenable = 1'b1; wr_bank_sel = 4'd1; waddr = 7'd106;
    wdata = 64'h0000_0088_0000_0077; wstrb = 2'b01;
    #1;
    chk("vcc_no_byp", vcc[1], 0);
    chk("vccz_before", vccz[1], 1);
    step();
    wenable = 1'b0;
    vcc_data = 32'hABC;
    #1;
    chk("vcc_alu_wins", vcc[1], 32'h77);
    chk("vccz_set", vccz[1], 0);
    step();
    vcc_en = 1'b0;
    chk("vcc_side", vcc[1], 32'hABC);
    rd(4'd1, 7'd106, "vcc_read", 32'h0, 32'hABC);

    // EXEC_LO cleared: wave32-only flag ignores the still-set high dword
    wave64_mode = 1'b1;
    wenable = 1'b1; wr_bank_sel = 4'd0; waddr = 7'd126; wdata = 64'h0; wstrb = 2'b01;
    step();
    wenable = 1'b0;
    chk("execz_w32", execz, 16'h0001);
    chk("exec0", exec[0], 0);
    rd(4'd0, 7'd126, "exec_read", 32'hFFFF_FFFF, 32'h0);
    wave64_mode = 1'b0;

    // Reset during beat 3 of a cnt-4 burst with another burst queued
    push(4'd11, 7'd4, 3'd4, 32'hA00);
    step();
    push(4'd12, 7'd0, 3'd1, 32'hB00);
    step();
    lsu_valid = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    step();
    chk("mid_rst_ready", lsu_ready, 0);
    chk("mid_rst_pend", lsu_pending, 0);
    reset = 1'b0;
    rd(4'd11, 7'd4, "mid_rst_r4", 32'h0, 32'h0);
    rd(4'd11, 7'd8, "mid_rst_r8", 32'h0, 32'h0);
    rd(4'd12, 7'd0, "mid_rst_q", 32'h0, 32'h0);
    chk("mid_rst_exec", exec[11], 32'hFFFF_FFFF);
    chk("mid_rst_execz", execz, 0);
    step();
    chk("mid_rst_ready2", lsu_ready, 1);
    step(); step();
    chk("mid_rst_idle", lsu_pending, 0);
    rd(4'd12, 7'd0, "mid_rst_q2", 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
